// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 types, sizes and sigma helpers for scheduler and core
package sha256_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int WORD_W = 32;
    localparam int ROUNDS = 64;
    localparam int WIN    = 16;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_scheduler.sv
// sha256_msg_scheduler: streams W0..W63 of one block through a 16-word sliding window
module sha256_msg_scheduler
    import sha256_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [511:0]      blk_i,
    input  logic              blk_valid,
    output logic              blk_ready,
    output logic [WORD_W-1:0] Wt_o,
    output logic              d_valid,
    input  logic              wt_ready,
    output logic [5:0]        w_idx,
    output logic              w_last
);

    state_t            state, state_nxt;
    logic [WORD_W-1:0] w [WIN];
    logic [5:0]        cnt;
    logic              accept, xfer, at_end;

    assign accept = blk_valid && state == IDLE;
    assign xfer   = wt_ready && state == RUN;
    assign at_end = cnt == 6'(ROUNDS - 1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and state-decoded outputs; data outputs are gated to zero outside RUN
    always_comb begin
        state_nxt = state;
        if (accept)                state_nxt = RUN;
        else if (xfer && at_end)   state_nxt = IDLE;
        blk_ready = state == IDLE;
        d_valid   = state == RUN;
        Wt_o      = d_valid ? w[0] : '0;
        w_idx     = d_valid ? cnt : '0;
        w_last    = d_valid && at_end;
    end

    // Window load on accept, shift-and-expand on every transfer, counter tracks t
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            for (int i = 0; i < WIN; i++) w[i] <= '0;
        end else if (accept) begin
            cnt <= '0;
            for (int i = 0; i < WIN; i++) w[i] <= blk_i[511 - WORD_W*i -: WORD_W];
        end else if (xfer) begin
            cnt <= at_end ? 6'd0 : cnt + 6'd1;
            for (int i = 0; i < WIN - 1; i++) w[i] <= w[i+1];
            w[WIN-1] <= ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
        end
    end

endmodule

// File: doc/sha256_msg_scheduler.md
# sha256_msg_scheduler

Message-schedule generator for the SHA-256 datapath. It accepts one 512-bit padded message block and emits the 64 schedule words W0..W63, one per accepted cycle. The output is a `Wt_o`/`d_valid` stream that feeds the compression core's `Wt_i`/`d_valid` inputs directly. A 16-word sliding window is used, so no 64-word storage is needed.

## Interface
Parameters:
- none; SHA-256 widths are fixed (32-bit words, 16-word window, 64 rounds).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `blk_i`  in  512  padded message block; M0 = `blk_i[511:480]`, M15 = `blk_i[31:0]`.
- `blk_valid`  in  1  `blk_i` is valid.
- `blk_ready`  out  1  scheduler can accept a block.
- `Wt_o`  out  32  current schedule word Wt.
- `d_valid`  out  1  `Wt_o` is valid; connects to the core's `d_valid`.
- `wt_ready`  in  1  consumer takes `Wt_o` this cycle; tie high for the free-running core.
- `w_idx`  out  6  index t of the word on `Wt_o`.
- `w_last`  out  1  high with t = 63.

## Operation
- **States:**
  - IDLE: `blk_ready` = 1, `d_valid` = 0.
  - RUN: `blk_ready` = 0, `d_valid` = 1.
- **Block accept** (`blk_valid & blk_ready`, IDLE only):
  - load window `w[0..15]` with M0..M15;
  - clear the counter;
  - go to RUN.
- **In RUN:**
  - `Wt_o` = `w[0]`, `w_idx` = counter, `w_last` = (counter == 63).
- **Transfer** (`d_valid & wt_ready`):
  - shift `w[i] <= w[i+1]` for i = 0..14;
  - `w[15] <= ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0]`, all mod 2^32;
  - counter increments.
  - For t < 16 the word leaving `w[0]` is the raw Mt; the expansion is computed each transfer regardless of t.
- **Sigma functions** (R = rotate right, S = shift right):
  - `ssig0(x)` = R7 ^ R18 ^ S3;
  - `ssig1(x)` = R17 ^ R19 ^ S10.
- **Stall:** with `wt_ready` = 0 the window, counter, `Wt_o` and `w_idx` hold; `d_valid` stays 1.
- **End of block:** a transfer with counter = 63 returns to IDLE and clears the counter.
- **Outside RUN:** `Wt_o`, `w_idx` and `w_last` read 0.
- **Ignored input:** `blk_valid` is ignored in RUN. No queueing; the producer must hold the block until `blk_ready`.
- **Counter width:** 6-bit, wraps 63 → 0 only via the end-of-block transition.

## Timing
- **Reset** (`rst` high at an edge): next cycle shows
  - IDLE, `blk_ready` = 1, `d_valid` = 0, `Wt_o` = 0, `w_idx` = 0, `w_last` = 0;
  - window cleared.
  - `rst` overrides every other input in the same cycle.
- **Reset mid-block:** abandons the block. No further `d_valid`; the partial stream is not resumed.
- **Latency:** block accepted at edge N → W0 valid in the cycle after edge N.
- **Throughput:** with `wt_ready` = 1, W63 is presented in cycle N+64. `blk_ready` is high again after edge N+64, giving 65 cycles per block (one IDLE bubble).
- **No back-to-back:** `blk_ready` is never high in the same cycle as `w_last`.
- **Registered outputs:** `Wt_o` comes from the window register with no combinational path from inputs. `blk_ready` and `d_valid` are decoded from the state register only.

## Structure
- **Package `sha256_pkg`:**
  - state enum `{IDLE, RUN}`;
  - `WORD_W` = 32, `ROUNDS` = 64, `WIN` = 16;
  - functions `rotr`, `ssig0`, `ssig1`.
  - The package is also intended for the compression core's `Ch`/`Maj`/`Sigma` and K-ROM, so both ends share one definition.
- **Sub-modules:** none. The window, counter and FSM stay in one module; the expansion adder is a single package function call.

## Test plan
- **"abc" block** (`blk_i` = 0x61626380, 0 ×14, 0x00000018), `wt_ready` = 1 → expected stream:
  - W0 = 0x61626380, W1..W14 = 0, W15 = 0x18;
  - W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405;
  - 64 consecutive `d_valid` cycles with `w_last` on t = 63;
  - `blk_ready` is 0 throughout and high the cycle after.
- **Random stalls:** random `wt_ready` on the "abc" block → the same 64-word sequence is transferred. `Wt_o` and `w_idx` are stable while stalled, and exactly 64 transfers occur.
- **Random blocks:** 100 random blocks back-to-back → every word matches the reference-model schedule, with exactly one IDLE cycle between blocks.
- **Reset mid-block:** assert `rst` at t = 30 → next cycle `d_valid` = 0, `blk_ready` = 1, `w_idx` = 0. A new block then starts cleanly at W0.
- **Ignored blk_valid:** `blk_valid` held high during RUN with a different `blk_i` → the block is not accepted until IDLE, and the current stream is unaffected.
- **Integration:** scheduler driving the compression core on "abc" → digest = 0xBA7816BF 8F01CFEA 414140DE 5DAE2223 B00361A3 96177A9C B410FF61 F20015AD.
